frogg_game_ctrl: RTL



---
 rtl/frogg_game_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/frogg_game_ctrl.sv
// Frog game sequencer: per-frame hit/goal decision, lives/level/score keeping, frog respawn command.
// Latency: outputs are registered and update one cycle after the deciding frame tick.
// Backpressure: none; sampled every cycle. Optional FROGG_EXTRA_LIFE_EN grants a life every 4th goal.
module frogg_game_ctrl #(
  parameter int unsigned c_LIVES      = 3,
  parameter int unsigned c_MAX_LEVEL  = 7,
  parameter int unsigned c_GOAL_ROW_Y = 0,
  parameter int unsigned c_HIT_FRAMES = 60,
  parameter int unsigned c_WIN_FRAMES = 30
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Frame_Tick,
  input  logic       i_Start,
  input  logic       i_Draw_Frog,
  input  logic       i_Draw_Car,
  input  logic [9:0] i_Frog_Y,
  output logic       o_Game_Active,
  output logic       o_Frog_Respawn,
  output logic [1:0] o_Lives,
  output logic [2:0] o_Level,
  output logic [7:0] o_Score,
  output logic [2:0] o_State
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PLAY = 3'd1,
    S_HIT  = 3'd2,
    S_WIN  = 3'd3,
    S_OVER = 3'd4
  } state_t;

  localparam logic [1:0] LIVES_INIT = 2'(c_LIVES);
  localparam logic [2:0] MAX_LEVEL  = 3'(c_MAX_LEVEL);
  localparam logic [9:0] GOAL_Y     = 10'(c_GOAL_ROW_Y);
  localparam logic [7:0] HIT_FRAMES = 8'(c_HIT_FRAMES);
  localparam logic [7:0] WIN_FRAMES = 8'(c_WIN_FRAMES);

  state_t     state, state_next;
  logic [7:0] frame_cnt, frame_cnt_next;
  logic       coll_latch, coll_latch_next;
  logic       start_hist;
  logic [1:0] lives, lives_next;
  logic [2:0] level, level_next;
  logic [7:0] score, score_next;
  logic       game_active_next;
  logic       respawn_next;

  logic       start_edge;
  logic       collided;
  logic [7:0] cnt_inc;
  logic [7:0] score_inc;

  // Next-state, counters and scoring decisions; everything defaults to holding.
  always_comb begin
    state_next      = state;
    frame_cnt_next  = frame_cnt;
    coll_latch_next = 1'b0;
    lives_next      = lives;
    level_next      = level;
    score_next      = score;
    start_edge      = i_Start & ~start_hist;
    // A hazard overlap on the tick cycle itself still counts for that tick.
    collided        = coll_latch | (i_Draw_Frog & i_Draw_Car);
    cnt_inc         = frame_cnt + 8'd1;
    score_inc       = (score == 8'hFF) ? score : score + 8'd1;

    case (state)
      S_IDLE, S_OVER: begin
        if (start_edge) begin
          lives_next = LIVES_INIT;
          level_next = 3'd1;
          score_next = 8'd0;
          state_next = S_PLAY;
        end
      end
      S_PLAY: begin
        coll_latch_next = i_Frame_Tick ? 1'b0 : collided;
        if (i_Frame_Tick) begin
          if (collided) begin
            // Lives are always >=1 here: reaching 0 routes HIT to OVER.
            lives_next     = lives - 2'd1;
            frame_cnt_next = 8'd0;
            state_next     = S_HIT;
          end else if (i_Frog_Y == GOAL_Y) begin
            score_next     = score_inc;
            level_next     = (level >= MAX_LEVEL) ? MAX_LEVEL : level + 3'd1;
            frame_cnt_next = 8'd0;
            state_next     = S_WIN;
`ifdef FROGG_EXTRA_LIFE_EN
            if ((score_inc != 8'd0) && (score_inc[1:0] == 2'b00) && (lives < 2'd3)) begin
              lives_next = lives + 2'd1;
            end
`endif
          end
        end
      end
      S_HIT: begin
        if (i_Frame_Tick) begin
          frame_cnt_next = cnt_inc;
          if (cnt_inc == HIT_FRAMES) begin
            state_next = (lives == 2'd0) ? S_OVER : S_PLAY;
          end
        end
      end
      S_WIN: begin
        if (i_Frame_Tick) begin
          frame_cnt_next = cnt_inc;
          if (cnt_inc == WIN_FRAMES) begin
            state_next = S_PLAY;
          end
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Respawn only on entry into PLAY, so it can never last two cycles.
    respawn_next     = (state_next == S_PLAY) && (state != S_PLAY);
    game_active_next = (state_next == S_PLAY) || (state_next == S_HIT) ||
                       (state_next == S_WIN);
  end

  // State and datapath registers; history resets high so a held button cannot start a game.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state          <= S_IDLE;
      frame_cnt      <= 8'd0;
      coll_latch     <= 1'b0;
      start_hist     <= 1'b1;
      lives          <= 2'd0;
      level          <= 3'd0;
      score          <= 8'd0;
      o_Game_Active  <= 1'b0;
      o_Frog_Respawn <= 1'b0;
    end else begin
      state          <= state_next;
      frame_cnt      <= frame_cnt_next;
      coll_latch     <= coll_latch_next;
      start_hist     <= i_Start;
      lives          <= lives_next;
      level          <= level_next;
      score          <= score_next;
      o_Game_Active  <= game_active_next;
      o_Frog_Respawn <= respawn_next;
    end
  end

  assign o_Lives = lives;
  assign o_Level = level;
  assign o_Score = score;
  assign o_State = state;

endmodule
